// File: rtl/ifu_litebpu.sv
// ifu_litebpu - lite static branch predictor and JALR operand sequencer.
//
// Produces a static taken prediction and the two operands of the IFU next-PC
// adder from the mini-decoder outputs. JALR through x2..x31 borrows the shared
// regfile rs1 read port (IR stage has priority) and stalls fetch until the
// base register is free of hazards and has been read.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pc                       PC of the decoded instruction
//   dec_i_valid/dec_i_ready  decoder outputs valid / IFU consumes prediction
//   dec_jal/jalr/bxx         decoded branch class
//   dec_bjp_imm              sign-extended branch/jump immediate
//   dec_jalr_rs1idx          JALR base register index
//   oitf_empty, ir_empty     no outstanding long-pipe writes / IR stage empty
//   ir_rs1en                 IR stage owns the rs1 port this cycle
//   jalr_rs1idx_cam_irrdidx  IR-stage instruction writes the JALR base
//   bpu_flush                abort any JALR sequence
//   rf2bpu_x1, rf2bpu_rs1    forwarded x1 / shared rs1 port read data
//   bpu2rf_rs1_ena           claim of the shared rs1 port
//   bpu_wait                 IFU must hold instruction and PC
//   prdt_taken               predicted taken
//   prdt_pc_add_op1/op2      next-PC adder operands
module ifu_litebpu #(
   parameter int PC_SIZE = 32,
   parameter int XLEN    = 32,
   parameter int RFIDX_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PC_SIZE-1:0] pc,
   input  logic               dec_i_valid,
   input  logic               dec_i_ready,
   input  logic               dec_jal,
   input  logic               dec_jalr,
   input  logic               dec_bxx,
   input  logic [XLEN-1:0]    dec_bjp_imm,
   input  logic [RFIDX_W-1:0] dec_jalr_rs1idx,
   input  logic               oitf_empty,
   input  logic               ir_empty,
   input  logic               ir_rs1en,
   input  logic               jalr_rs1idx_cam_irrdidx,
   input  logic               bpu_flush,
   input  logic [XLEN-1:0]    rf2bpu_x1,
   input  logic [XLEN-1:0]    rf2bpu_rs1,
   output logic               bpu2rf_rs1_ena,
   output logic               bpu_wait,
   output logic               prdt_taken,
   output logic [PC_SIZE-1:0] prdt_pc_add_op1,
   output logic [PC_SIZE-1:0] prdt_pc_add_op2
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RD   = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [XLEN-1:0]    rs1_q, rs1_d;
   logic               rs1_ena;
   logic               out_en;
   logic               is_x0, is_x1, is_xn, jalr_xn, dep, x1_wait, xn_wait;
   logic [PC_SIZE-1:0] imm_pc, x1_pc, rs1_pc, rs1q_pc, xn_op1;

   // Width adaptation between XLEN data and PC_SIZE adder operands.
   generate
      if (PC_SIZE <= XLEN) begin : g_trunc
         assign imm_pc  = dec_bjp_imm[PC_SIZE-1:0];
         assign x1_pc   = rf2bpu_x1[PC_SIZE-1:0];
         assign rs1_pc  = rf2bpu_rs1[PC_SIZE-1:0];
         assign rs1q_pc = rs1_q[PC_SIZE-1:0];
      end else begin : g_ext
         assign imm_pc  = {{(PC_SIZE-XLEN){dec_bjp_imm[XLEN-1]}}, dec_bjp_imm};
         assign x1_pc   = {{(PC_SIZE-XLEN){1'b0}}, rf2bpu_x1};
         assign rs1_pc  = {{(PC_SIZE-XLEN){1'b0}}, rf2bpu_rs1};
         assign rs1q_pc = {{(PC_SIZE-XLEN){1'b0}}, rs1_q};
      end
   endgenerate

   // Outputs read as zero while reset is asserted, not only after the edge.
   assign out_en  = dec_i_valid & ~rst;

   assign is_x0   = (dec_jalr_rs1idx == RFIDX_W'(0));
   assign is_x1   = (dec_jalr_rs1idx == RFIDX_W'(1));
   assign is_xn   = ~is_x0 & ~is_x1;
   assign jalr_xn = dec_i_valid & dec_jalr & is_xn;
   assign dep     = ~oitf_empty | (~ir_empty & jalr_rs1idx_cam_irrdidx);

   always_comb begin
      state_d = state_q;
      rs1_d   = rs1_q;
      rs1_ena = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (jalr_xn) begin
               if (dep | ir_rs1en) begin
                  state_d = ST_WAIT;
               end else begin
                  rs1_ena = 1'b1;
                  state_d = ST_RD;
               end
            end
         end
         ST_WAIT: begin
            if (~dep & ~ir_rs1en) begin
               rs1_ena = 1'b1;
               state_d = ST_RD;
            end
         end
         ST_RD: begin
            rs1_d   = rf2bpu_rs1;
            state_d = dec_i_ready ? ST_IDLE : ST_HOLD;
         end
         ST_HOLD: begin
            if (dec_i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (bpu_flush) begin
         state_d = ST_IDLE;
         rs1_ena = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rs1_q   <= '0;
      end else begin
         state_q <= state_d;
         rs1_q   <= rs1_d;
      end
   end

   assign x1_wait = is_x1 & (~oitf_empty | jalr_rs1idx_cam_irrdidx);
   assign xn_wait = is_xn & ((state_q == ST_WAIT) | (state_q == ST_IDLE));

   always_comb begin
      xn_op1 = '0;
      if (state_q == ST_RD)        xn_op1 = rs1_pc;
      else if (state_q == ST_HOLD) xn_op1 = rs1q_pc;
   end

   assign bpu2rf_rs1_ena  = out_en & rs1_ena;
   assign bpu_wait        = out_en & dec_jalr & (x1_wait | xn_wait);
   assign prdt_taken      = out_en & (dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[XLEN-1]));
   assign prdt_pc_add_op2 = out_en ? imm_pc : '0;

   always_comb begin
      prdt_pc_add_op1 = '0;
      if (out_en) begin
         if (!dec_jalr)  prdt_pc_add_op1 = pc;
         else if (is_x0) prdt_pc_add_op1 = '0;
         else if (is_x1) prdt_pc_add_op1 = x1_pc;
         else            prdt_pc_add_op1 = xn_op1;
      end
   end

endmodule

// File: tb/tb_ifu_litebpu.sv
module tb_ifu_litebpu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc;
   logic        dec_i_valid, dec_i_ready, dec_jal, dec_jalr, dec_bxx;
   logic [31:0] dec_bjp_imm;
   logic [4:0]  dec_jalr_rs1idx;
   logic        oitf_empty, ir_empty, ir_rs1en, jalr_rs1idx_cam_irrdidx, bpu_flush;
   logic [31:0] rf2bpu_x1, rf2bpu_rs1;
   logic        bpu2rf_rs1_ena, bpu_wait, prdt_taken;
   logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic        tk;
      logic [31:0] op1;
      logic [31:0] op2;
      logic        wt;
      logic        ena;
   } exp_t;

   exp_t sb[$];

   ifu_litebpu #(.PC_SIZE(32), .XLEN(32), .RFIDX_W(5)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .pc                     (pc),
      .dec_i_valid            (dec_i_valid),
      .dec_i_ready            (dec_i_ready),
      .dec_jal                (dec_jal),
      .dec_jalr               (dec_jalr),
      .dec_bxx                (dec_bxx),
      .dec_bjp_imm            (dec_bjp_imm),
      .dec_jalr_rs1idx        (dec_jalr_rs1idx),
      .oitf_empty             (oitf_empty),
      .ir_empty               (ir_empty),
      .ir_rs1en               (ir_rs1en),
      .jalr_rs1idx_cam_irrdidx(jalr_rs1idx_cam_irrdidx),
      .bpu_flush              (bpu_flush),
      .rf2bpu_x1              (rf2bpu_x1),
      .rf2bpu_rs1             (rf2bpu_rs1),
      .bpu2rf_rs1_ena         (bpu2rf_rs1_ena),
      .bpu_wait               (bpu_wait),
      .prdt_taken             (prdt_taken),
      .prdt_pc_add_op1        (prdt_pc_add_op1),
      .prdt_pc_add_op2        (prdt_pc_add_op2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected outputs for the cycle just driven; op1 = 'x means unconstrained.
   task automatic push_exp(input string tag, input logic tk, input logic [31:0] op1,
                           input logic [31:0] op2, input logic wt, input logic ena);
      exp_t e;
      e.tag = tag; e.tk = tk; e.op1 = op1; e.op2 = op2; e.wt = wt; e.ena = ena;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.tag, ".taken"}, 32'(prdt_taken), 32'(e.tk));
         if (!$isunknown(e.op1)) chk({e.tag, ".op1"}, prdt_pc_add_op1, e.op1);
         chk({e.tag, ".op2"}, prdt_pc_add_op2, e.op2);
         chk({e.tag, ".wait"}, 32'(bpu_wait), 32'(e.wt));
         chk({e.tag, ".ena"}, 32'(bpu2rf_rs1_ena), 32'(e.ena));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      pc = '0; dec_i_valid = 0; dec_i_ready = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
      dec_bjp_imm = '0; dec_jalr_rs1idx = '0; oitf_empty = 1; ir_empty = 1; ir_rs1en = 0;
      jalr_rs1idx_cam_irrdidx = 0; bpu_flush = 0; rf2bpu_x1 = '0; rf2bpu_rs1 = '0;
   endtask

   task automatic jalr_in(input logic [4:0] idx, input logic [31:0] imm, input logic rdy);
      clr_in();
      dec_i_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = idx; dec_bjp_imm = imm;
      pc = 32'h0000_0500; dec_i_ready = rdy;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      clr_in();
      // Reset: outputs forced to zero even with a valid JAL presented.
      cyc();
      dec_i_valid = 1; dec_jal = 1; pc = 32'h100; dec_bjp_imm = 32'h20;
      push_exp("reset", 0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      chk("reset.rs1_q", dut.rs1_q, 32'h0);

      cyc(); rst = 0; clr_in(); dec_jal = 1; pc = 32'h100; dec_bjp_imm = 32'h20;
      push_exp("novalid", 0, 32'h0, 32'h0, 0, 0);

      cyc(); dec_i_valid = 1; dec_i_ready = 1;
      push_exp("jal", 1, 32'h100, 32'h20, 0, 0);

      cyc(); clr_in(); dec_i_valid = 1; dec_i_ready = 1; dec_bxx = 1; pc = 32'h200; dec_bjp_imm = 32'hFFFF_FFF0;
      push_exp("bxx_back", 1, 32'h200, 32'hFFFF_FFF0, 0, 0);
      cyc(); dec_bjp_imm = 32'h10;
      push_exp("bxx_fwd", 0, 32'h200, 32'h10, 0, 0);

      cyc(); clr_in(); dec_i_valid = 1; dec_i_ready = 1; pc = 32'h300; dec_bjp_imm = 32'h4;
      push_exp("nonbr", 0, 32'h300, 32'h4, 0, 0);

      cyc(); jalr_in(5'd0, 32'h40, 1);
      push_exp("jalr_x0", 1, 32'h0, 32'h40, 0, 0);

      // JALR x1 stalled three cycles by outstanding long-pipe writes.
      for (int unsigned i = 0; i < 3; i++) begin
         cyc(); jalr_in(5'd1, 32'h0, 0); rf2bpu_x1 = 32'h8000; oitf_empty = 0;
         push_exp("jalr_x1_wait", 1, 32'h8000, 32'h0, 1, 0);
      end
      cyc(); oitf_empty = 1; dec_i_ready = 1;
      push_exp("jalr_x1_go", 1, 32'h8000, 32'h0, 0, 0);

      // JALR x5: IR stage holds the port two cycles, IFU not ready for two.
      cyc(); jalr_in(5'd5, 32'h8, 0); ir_rs1en = 1;
      push_exp("x5_idle", 1, 'x, 32'h8, 1, 0);
      cyc();
      push_exp("x5_wait1", 1, 'x, 32'h8, 1, 0);
      cyc(); ir_rs1en = 0;
      push_exp("x5_wait2", 1, 'x, 32'h8, 1, 1);
      cyc(); rf2bpu_rs1 = 32'h2000;
      push_exp("x5_rd", 1, 32'h2000, 32'h8, 0, 0);
      cyc(); rf2bpu_rs1 = 32'hDEAD_BEEF;
      push_exp("x5_hold1", 1, 32'h2000, 32'h8, 0, 0);
      cyc(); dec_i_ready = 1;
      push_exp("x5_hold2", 1, 32'h2000, 32'h8, 0, 0);
      cyc(); clr_in();
      push_exp("x5_done", 0, 32'h0, 32'h0, 0, 0);

      // JALR x6, CAM hit while IR empty is no hazard: one stall cycle.
      cyc(); jalr_in(5'd6, 32'h10, 1); ir_empty = 1; jalr_rs1idx_cam_irrdidx = 1;
      push_exp("x6_claim", 1, 'x, 32'h10, 1, 1);
      cyc(); rf2bpu_rs1 = 32'h3000;
      push_exp("x6_rd", 1, 32'h3000, 32'h10, 0, 0);

      // Flush in WAIT while the hazard clears: no claim, back to IDLE.
      cyc(); jalr_in(5'd7, 32'h14, 0); ir_empty = 0; jalr_rs1idx_cam_irrdidx = 1;
      push_exp("flw_idle", 1, 'x, 32'h14, 1, 0);
      cyc(); jalr_rs1idx_cam_irrdidx = 0; bpu_flush = 1;
      push_exp("flw_flush", 1, 'x, 32'h14, 1, 0);
      cyc(); clr_in();
      push_exp("flw_drop", 0, 32'h0, 32'h0, 0, 0);
      cyc(); jalr_in(5'd7, 32'h14, 0);
      push_exp("flr_claim", 1, 'x, 32'h14, 1, 1);
      cyc(); rf2bpu_rs1 = 32'h4000; bpu_flush = 1;
      push_exp("flr_flush", 1, 32'h4000, 32'h14, 0, 0);
      cyc(); clr_in();
      push_exp("flr_drop", 0, 32'h0, 32'h0, 0, 0);
      cyc(); jalr_in(5'd7, 32'h14, 0); ir_rs1en = 1;
      push_exp("flr_isidle", 1, 'x, 32'h14, 1, 0);
      cyc(); bpu_flush = 1;
      push_exp("flr_clear", 1, 'x, 32'h14, 1, 0);
      cyc(); clr_in();
      push_exp("flr_drop2", 0, 32'h0, 32'h0, 0, 0);

      // Reset asserted while in HOLD.
      cyc(); jalr_in(5'd5, 32'h18, 0);
      push_exp("rh_claim", 1, 'x, 32'h18, 1, 1);
      cyc(); rf2bpu_rs1 = 32'h5000;
      push_exp("rh_rd", 1, 32'h5000, 32'h18, 0, 0);
      cyc(); rf2bpu_rs1 = 32'h0;
      push_exp("rh_hold", 1, 32'h5000, 32'h18, 0, 0);
      cyc(); rst = 1;
      push_exp("rh_reset", 0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      chk("rh_reset.rs1_q", dut.rs1_q, 32'h0);
      cyc(); rst = 0; jalr_in(5'd5, 32'h18, 1);
      push_exp("rh_idle", 1, 'x, 32'h18, 1, 1);
      cyc(); rf2bpu_rs1 = 32'h6000;
      push_exp("rh_rd2", 1, 32'h6000, 32'h18, 0, 0);
      cyc(); clr_in();
      push_exp("rh_end", 0, 32'h0, 32'h0, 0, 0);

      for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      chk("drain", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifu_litebpu.md
# ifu_litebpu

Lite branch-prediction and JALR-operand sequencer in the IFU. It sits beside the IFU mini-decoder and consumes its `dec_jal` / `dec_jalr` / `dec_bxx` / `dec_bjp_imm` / `dec_jalr_rs1idx` outputs. From these it produces a static taken prediction and the two operands of the IFU next-PC adder. For JALR through a general register, it shares the regfile rs1 read port with the IR stage and stalls fetch until the operand is safe and read.

## Interface
- `PC_SIZE`, 32, width of PC and adder operands
- `XLEN`, 32, data and immediate width
- `RFIDX_W`, 5, register index width
- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `pc`  in  PC_SIZE  PC of the decoded instruction
- `dec_i_valid`  in  1  mini-decoder outputs are valid this cycle
- `dec_i_ready`  in  1  IFU consumes the prediction this cycle
- `dec_jal`, `dec_jalr`, `dec_bxx`  in  1 each  decoded branch class
- `dec_bjp_imm`  in  XLEN  sign-extended branch/jump immediate
- `dec_jalr_rs1idx`  in  RFIDX_W  JALR base register
- `oitf_empty`  in  1  no outstanding long-pipe writebacks
- `ir_empty`  in  1  IR stage holds no instruction
- `ir_rs1en`  in  1  IR stage uses the rs1 read port this cycle
- `jalr_rs1idx_cam_irrdidx`  in  1  IR-stage instruction writes `dec_jalr_rs1idx`
- `bpu_flush`  in  1  pipeline flush; abort any JALR sequence
- `rf2bpu_x1`  in  XLEN  forwarded x1 value
- `rf2bpu_rs1`  in  XLEN  shared rs1 port read data, valid the cycle after the port is claimed
- `bpu2rf_rs1_ena`  out  1  claims the shared rs1 read port; index is `dec_jalr_rs1idx`
- `bpu_wait`  out  1  IFU must hold the current instruction and the PC
- `prdt_taken`  out  1  predicted taken
- `prdt_pc_add_op1`  out  PC_SIZE  adder operand 1
- `prdt_pc_add_op2`  out  PC_SIZE  adder operand 2

## Operation
- All outputs are gated by `dec_i_valid`. When `dec_i_valid` is 0, all outputs are 0.
- JAL: taken = 1, op1 = `pc`, op2 = imm.
- Bxx: taken = `dec_bjp_imm[XLEN-1]` (backward taken, forward not taken), op1 = `pc`, op2 = imm.
- Non-branch: taken = 0, op1 = `pc`, op2 = imm (don't-care to the IFU).
- JALR: taken = 1, op2 = imm. op1 depends on the base register:
  - rs1 = x0: op1 = 0, no wait.
  - rs1 = x1: op1 = `rf2bpu_x1`. `bpu_wait` is asserted while `!oitf_empty | jalr_rs1idx_cam_irrdidx`. No state is used.
  - rs1 = xn (n ≥ 2): sequenced by the FSM below.
- dep = `!oitf_empty | (!ir_empty & jalr_rs1idx_cam_irrdidx)`.
- FSM states: IDLE, WAIT, RD, HOLD. Reset state is IDLE.
  - IDLE, on JALR-xn with `dec_i_valid`:
    - If dep or `ir_rs1en`: go to WAIT, `bpu_wait` = 1.
    - Else: `bpu2rf_rs1_ena` = 1, go to RD, `bpu_wait` = 1.
  - WAIT: `bpu_wait` = 1. When dep = 0 and `ir_rs1en` = 0: `bpu2rf_rs1_ena` = 1, go to RD.
  - RD: `rf2bpu_rs1` is captured into `rs1_q`. op1 = `rf2bpu_rs1`, `bpu_wait` = 0.
    - If `dec_i_ready`: go to IDLE.
    - Else: go to HOLD.
  - HOLD: op1 = `rs1_q`, `bpu_wait` = 0. Go to IDLE on `dec_i_ready`.
- The IR stage always has priority for the rs1 port. `bpu2rf_rs1_ena` and `ir_rs1en` are never both 1.
- `bpu_flush` in any state: next state is IDLE, and `bpu2rf_rs1_ena` is forced to 0 in that cycle. Flush has priority over every other transition.
- `dec_i_valid` dropping in WAIT, RD or HOLD without a flush is illegal; the block behaviour is undefined.
- Widths:
  - op2 = `dec_bjp_imm[PC_SIZE-1:0]` (sign-extended if PC_SIZE > XLEN).
  - op1 for a register base = register value truncated to PC_SIZE.
  - Addition and wrap-around happen in the IFU adder, not in this block.

## Timing
- Reset (async): state = IDLE, `rs1_q` = 0, all outputs 0.
- JAL, Bxx, x0 and ready x1: prediction is combinational, same cycle, zero latency.
- JALR-xn with no hazard:
  - Cycle 0: `bpu_wait` = 1, `bpu2rf_rs1_ena` = 1.
  - Cycle 1: data presented, `bpu_wait` = 0.
  - Minimum latency is 1 stall cycle.
- Each cycle spent in WAIT adds one stall cycle.
- The port is claimed for exactly one cycle per JALR.
- A hazard that clears in the same cycle it is sampled is taken as clear: ena is asserted that cycle.

## Test plan
- JAL, pc=0x100, imm=0x20 -> taken=1, op1=0x100, op2=0x20, wait=0, same cycle.
- Bxx with imm=0xFFFFFFF0 -> taken=1; Bxx with imm=0x10 -> taken=0; op1=pc in both.
- JALR x1, `oitf_empty`=0 for 3 cycles, x1=0x8000 -> wait=1 for 3 cycles, then op1=0x8000, wait=0.
- JALR x5, `ir_rs1en`=1 for 2 cycles, `rf2bpu_rs1`=0x2000, `dec_i_ready` low for 2 cycles -> WAIT 2 cycles, ena pulse 1 cycle, RD then HOLD 2 cycles with op1=0x2000 from `rs1_q`, then IDLE.
- `bpu_flush` in WAIT and in RD -> IDLE next cycle, no ena in the flush cycle, wait=0 once `dec_i_valid` drops.
- `rst` asserted mid-HOLD -> outputs 0 immediately, `rs1_q`=0, IDLE after release.
